fork_join_ctrl: RTL and testbench
=================================

Name: fork_join_ctrl

Overview:
- Hardware launcher for N parallel timed jobs ("branches"). It starts all enabled branches together and tracks each to completion.
- Signals the join point according to a selectable join mode: all, any, none, or any-with-kill.
- Sits between the sequencer that issues job groups and the per-branch consumers of the done/killed events.
- Supports an external "disable fork" that aborts every running branch.

Parameters:
- N_CH, 4, number of parallel branches (2..8).
- CNT_W, 8, width of each branch delay counter.
- ID_W, 2, width of first_id; must equal clog2(N_CH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; accepted only when busy=0.
- mode  in  2  join mode sampled on accepted start: 0=JOIN_ALL, 1=JOIN_ANY, 2=JOIN_NONE, 3=JOIN_ANY_KILL.
- en_mask  in  N_CH  branch enables, sampled on accepted start.
- delay  in  N_CH*CNT_W  per-branch delay in cycles, branch i at bits [i*CNT_W +: CNT_W], sampled on accepted start.
- disable_i  in  1  kill all running branches.
- busy  out  1  any branch running, or join not yet issued.
- running  out  N_CH  per-branch active flag.
- ch_done  out  N_CH  one-cycle pulse when a branch completes normally.
- ch_killed  out  N_CH  sticky flag for each branch terminated by kill; cleared on next accepted start.
- join_done  out  1  one-cycle pulse marking the join point; exactly one per launch.
- first_id  out  ID_W  index of the first-finishing branch; valid from join_done in ANY modes, held until next start.
- aborted  out  1  sticky; set when disable_i killed at least one branch; cleared on accepted start.

Behaviour:
- Reset: rst=1 at an edge sets all outputs and state to 0 and returns the FSM to IDLE, including mid-operation. No pulses are emitted in the cycle after reset.
- FSM states: IDLE, RUN (join pending), DETACHED (join issued, branches still running).
- Accept: start=1 and state IDLE at edge k. Capture mode/en_mask/delay. Clear ch_killed, aborted and first_id. Set running=en_mask.
- Accept with en_mask=0: the launch is empty. join_done pulses after edge k+1, and the FSM returns to IDLE.
- Start while busy=1 is ignored; no queuing.
- Timing: a delay value of 0 is treated as 1. Branch i with delay d completes at edge k+d: ch_done[i]=1 for that one cycle and running[i] falls at the same edge.
- JOIN_ALL: join_done pulses at the edge the last running branch completes, then IDLE.
- JOIN_ANY: join_done pulses at the first completion edge, then DETACHED. Remaining branches run to completion; IDLE follows when running=0.
- JOIN_NONE: join_done pulses at edge k+1, then DETACHED.
- JOIN_ANY_KILL: at the first completion edge, join_done pulses and first_id is set. All other still-running branches are cleared and their ch_killed bits set. Then IDLE.
- Simultaneous completions: all branches finishing on the same edge get ch_done. None of them is killed. first_id = lowest finishing index.
- Any-mode join with JOIN_NONE: if the first completion coincides with the JOIN_NONE join edge (delay 1), join_done still pulses once only.
- disable_i=1 at an edge with running≠0:
  - running branches are cleared, their ch_killed bits set, and aborted set;
  - join_done pulses at that edge if not yet issued for this launch;
  - the FSM goes to IDLE.
- disable_i is ignored in IDLE or when running=0.
- disable_i and a completion on the same edge: the completing branch gets ch_done, not killed. Kill applies to the rest.
- start and disable_i together while busy: disable_i wins. Start is ignored that edge.
- busy=1 from edge k until the FSM returns to IDLE. It falls at the same edge as the final ch_done, kill, or empty-launch join_done.

Test Plan:
- JOIN_ANY_KILL, en_mask=4'b1111, delays {2,3,4,5} (ch0..ch3), start at edge 0:
  - ch_done[0] at edge 2 and join_done at edge 2, first_id=0;
  - ch_killed=4'b1110, busy=0 after edge 2;
  - no ch_done on ch1..ch3.
- JOIN_NONE, delays {1,2,3,10}, start at edge 0:
  - join_done at edge 1 (coincides with ch_done[0], one pulse only);
  - ch_done at edges 1,2,3,10;
  - busy falls at edge 10; ch_killed=0.
- JOIN_ALL, delays {3,3,7,0}, en_mask=4'b0111:
  - ch_done[0] and ch_done[1] at edge 3, ch_done[2] at edge 7;
  - join_done at edge 7; ch3 never runs.
- JOIN_ANY, delays {5,4,4,9}:
  - ch_done[1] and ch_done[2] at edge 4, join_done at edge 4, first_id=1;
  - ch_done[0] at edge 5, ch_done[3] at edge 9; busy falls at edge 9.
- JOIN_ALL, delays {10,10,10,10}, disable_i pulsed at edge 6:
  - ch_killed=4'b1111, aborted=1, join_done at edge 6;
  - start at edge 6 ignored; start at edge 7 accepted, clears ch_killed and aborted.
- JOIN_ANY, delays {8,8,8,8}, rst at edge 3:
  - all outputs 0 after edge 3; no ch_done at edge 8;
  - a new start at edge 4 behaves normally.

Source files
------------

// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl
// Launches up to N_CH timed branches together and reports their completion
// and the join point, which depends on the join mode captured at launch:
// all, any, none, or any-with-kill. An external disable aborts all running
// branches.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   start      launch request, honoured only while idle
//   mode       join mode (0 all, 1 any, 2 none, 3 any-with-kill)
//   en_mask    per-branch enables
//   delay      per-branch delays, branch i at [i*CNT_W +: CNT_W]
//   disable_i  kill every running branch
//   busy       launch in progress (branches running or join pending)
//   running    per-branch active flags
//   ch_done    one-cycle pulse per branch on normal completion
//   ch_killed  sticky per-branch kill flags, cleared on launch
//   join_done  one-cycle join pulse, exactly one per launch
//   first_id   lowest index among the first finishers (any modes)
//   aborted    sticky, set when disable_i killed at least one branch
module fork_join_ctrl #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [N_CH-1:0]       en_mask,
  input  logic [N_CH*CNT_W-1:0] delay,
  input  logic                  disable_i,
  output logic                  busy,
  output logic [N_CH-1:0]       running,
  output logic [N_CH-1:0]       ch_done,
  output logic [N_CH-1:0]       ch_killed,
  output logic                  join_done,
  output logic [ID_W-1:0]       first_id,
  output logic                  aborted
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,  // join still pending
    S_DETACHED = 2'd2   // join issued, branches still running
  } state_t;

  localparam logic [1:0] M_ALL      = 2'd0;
  localparam logic [1:0] M_ANY      = 2'd1;
  localparam logic [1:0] M_NONE     = 2'd2;
  localparam logic [1:0] M_ANY_KILL = 2'd3;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [N_CH-1:0]   running_q, running_d;
  logic [N_CH-1:0]   ch_done_q, ch_done_d;
  logic [N_CH-1:0]   ch_killed_q, ch_killed_d;
  logic              join_done_q, join_done_d;
  logic [ID_W-1:0]   first_id_q, first_id_d;
  logic              aborted_q, aborted_d;

  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic [N_CH-1:0]   fin;       // branches completing at this edge
  logic [N_CH-1:0]   rest;      // branches still running after this edge
  logic [ID_W-1:0]   fin_id;
  logic              launch;

  assign launch = (state_q == S_IDLE) && start;

  // Per-branch down-counters. A counter holding 1 means the branch
  // completes at the coming edge, so a delay d finishes d edges after launch.
  // A zero delay is loaded as 1.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_branch
      logic [CNT_W-1:0] dval;
      assign dval    = delay[gi*CNT_W +: CNT_W];
      assign fin[gi] = running_q[gi] && (cnt_q[gi] == CNT_W'(1));

      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (launch) begin
          cnt_d[gi] = (dval == '0) ? CNT_W'(1) : dval;
        end else if (running_q[gi] && !fin[gi]) begin
          cnt_d[gi] = cnt_q[gi] - CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign rest = running_q & ~fin;

  // Lowest-index finisher wins ties
  always_comb begin
    fin_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (fin[i]) fin_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    running_d   = running_q;
    ch_done_d   = '0;
    ch_killed_d = ch_killed_q;
    join_done_d = 1'b0;
    first_id_d  = first_id_q;
    aborted_d   = aborted_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          running_d   = en_mask;
          ch_killed_d = '0;
          aborted_d   = 1'b0;
          first_id_d  = '0;
          state_d     = S_RUN;
        end
      end

      S_RUN, S_DETACHED: begin
        // Completions on this edge always count as normal finishes, even
        // when a disable or an any-kill join arrives on the same edge.
        ch_done_d = fin;
        if (disable_i && (|running_q)) begin
          running_d   = '0;
          ch_killed_d = ch_killed_q | rest;
          if (|rest) aborted_d = 1'b1;
          if (state_q == S_RUN) begin
            join_done_d = 1'b1;
            if (((mode_q == M_ANY) || (mode_q == M_ANY_KILL)) && (|fin)) begin
              first_id_d = fin_id;
            end
          end
          state_d = S_IDLE;
        end else begin
          running_d = rest;
          if (state_q == S_RUN) begin
            case (mode_q)
              M_ALL: begin
                if (rest == '0) begin
                  join_done_d = 1'b1;
                  state_d     = S_IDLE;
                end
              end
              M_ANY: begin
                // An empty launch joins immediately
                if ((|fin) || (running_q == '0)) begin
                  join_done_d = 1'b1;
                  if (|fin) first_id_d = fin_id;
                  state_d = (rest == '0) ? S_IDLE : S_DETACHED;
                end
              end
              M_NONE: begin
                join_done_d = 1'b1;
                state_d     = (rest == '0) ? S_IDLE : S_DETACHED;
              end
              default: begin  // M_ANY_KILL
                if ((|fin) || (running_q == '0)) begin
                  join_done_d = 1'b1;
                  if (|fin) first_id_d = fin_id;
                  ch_killed_d = ch_killed_q | rest;
                  running_d   = '0;
                  state_d     = S_IDLE;
                end
              end
            endcase
          end else if (rest == '0) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        running_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= M_ALL;
      running_q   <= '0;
      ch_done_q   <= '0;
      ch_killed_q <= '0;
      join_done_q <= 1'b0;
      first_id_q  <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      running_q   <= running_d;
      ch_done_q   <= ch_done_d;
      ch_killed_q <= ch_killed_d;
      join_done_q <= join_done_d;
      first_id_q  <= first_id_d;
      aborted_q   <= aborted_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign running   = running_q;
  assign ch_done   = ch_done_q;
  assign ch_killed = ch_killed_q;
  assign join_done = join_done_q;
  assign first_id  = first_id_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Testbench for fork_join_ctrl: directed launches, an event-time reference
// model compared on every cycle, and literal expectations at key edges.
module tb_fork_join_ctrl;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, start, disable_i;
  logic [1:0]     mode;
  logic [N-1:0]   en_mask;
  logic [N*W-1:0] delay;
  logic           busy, join_done, aborted;
  logic [N-1:0]   running, ch_done, ch_killed;
  logic [1:0]     first_id;

  fork_join_ctrl #(.N_CH(N), .CNT_W(W), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .en_mask(en_mask),
    .delay(delay), .disable_i(disable_i), .busy(busy), .running(running),
    .ch_done(ch_done), .ch_killed(ch_killed), .join_done(join_done),
    .first_id(first_id), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each branch owns an absolute finish edge number
  int           edge_no = 0;
  int           m_phase = 0;   // 0 idle, 1 join pending, 2 join issued
  logic [1:0]   m_mode = 2'd0;
  int           m_end [N];
  logic [N-1:0] m_run = '0, m_done = '0, m_killed = '0;
  logic         m_join = 1'b0, m_aborted = 1'b0;
  logic [1:0]   m_first = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, edge_no, act, exp);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [N-1:0] v);
    logic [1:0] r = 2'd0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic model_edge();
    logic [N-1:0] fin, rest;
    int d;
    bit any_mode;
    edge_no++;
    m_done = '0;
    m_join = 1'b0;
    if (rst) begin
      m_phase = 0; m_mode = 2'd0; m_run = '0; m_killed = '0;
      m_aborted = 1'b0; m_first = 2'd0;
      return;
    end
    if (m_phase == 0) begin
      if (start) begin
        m_mode = mode; m_run = en_mask; m_killed = '0; m_aborted = 1'b0;
        m_first = 2'd0; m_phase = 1;
        for (int i = 0; i < N; i++) begin
          d = int'(delay[i*W +: W]);
          if (d == 0) d = 1;
          m_end[i] = edge_no + d;
        end
      end
      return;
    end
    fin = '0;
    for (int i = 0; i < N; i++) if (m_run[i] && m_end[i] == edge_no) fin[i] = 1'b1;
    rest = m_run & ~fin;
    m_done = fin;
    any_mode = (m_mode == 2'd1) || (m_mode == 2'd3);
    if (disable_i && m_run != '0) begin
      m_killed = m_killed | rest;
      if (rest != '0) m_aborted = 1'b1;
      if (m_phase == 1) begin
        m_join = 1'b1;
        if (any_mode && fin != '0) m_first = lowest(fin);
      end
      m_run = '0;
      m_phase = 0;
      return;
    end
    if (m_phase == 2) begin
      m_run = rest;
      if (rest == '0) m_phase = 0;
      return;
    end
    // join pending
    if (m_mode == 2'd0) begin
      m_run = rest;
      if (rest == '0) begin m_join = 1'b1; m_phase = 0; end
    end else if (m_mode == 2'd2) begin
      m_run = rest;
      m_join = 1'b1;
      m_phase = (rest == '0) ? 0 : 2;
    end else if (fin != '0 || m_run == '0) begin
      m_join = 1'b1;
      if (fin != '0) m_first = lowest(fin);
      if (m_mode == 2'd3) begin
        m_killed = m_killed | rest;
        m_run = '0;
        m_phase = 0;
      end else begin
        m_run = rest;
        m_phase = (rest == '0) ? 0 : 2;
      end
    end else begin
      m_run = rest;
    end
  endtask

  task automatic compare_all();
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("running", 32'(running), 32'(m_run));
    check("ch_done", 32'(ch_done), 32'(m_done));
    check("ch_killed", 32'(ch_killed), 32'(m_killed));
    check("join_done", 32'(join_done), 32'(m_join));
    check("first_id", 32'(first_id), 32'(m_first));
    check("aborted", 32'(aborted), 32'(m_aborted));
    $display("edge %0d: busy=%b run=%b done=%b killed=%b join=%b first=%0d abort=%b",
             edge_no, busy, running, ch_done, ch_killed, join_done, first_id, aborted);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic launch(input logic [1:0] md, input logic [N-1:0] en, input logic [N*W-1:0] dl);
    mode = md; en_mask = en; delay = dl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int jc;

  initial begin
    rst = 1'b1; start = 1'b0; disable_i = 1'b0; mode = 2'd0; en_mask = '0; delay = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_join", 32'(join_done), 32'd0);
    rst = 1'b0;
    tick();

    // any-with-kill, first finisher ch0 at edge 2
    launch(2'd3, 4'b1111, pk(2, 3, 4, 5));
    tick(); tick();
    check("t1_done", 32'(ch_done), 32'b0001);
    check("t1_join", 32'(join_done), 32'd1);
    check("t1_first", 32'(first_id), 32'd0);
    check("t1_killed", 32'(ch_killed), 32'b1110);
    check("t1_busy", 32'(busy), 32'd0);
    for (int e = 3; e <= 6; e++) begin
      tick();
      check("t1_no_done", 32'(ch_done), 32'd0);
    end

    // join none, delay-1 branch coincides with the join edge
    launch(2'd2, 4'b1111, pk(1, 2, 3, 10));
    jc = 0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      jc += int'(join_done);
      if (e == 1) begin
        check("t2_join1", 32'(join_done), 32'd1);
        check("t2_done1", 32'(ch_done), 32'b0001);
      end
      if (e == 2) check("t2_done2", 32'(ch_done), 32'b0010);
      if (e == 3) check("t2_done3", 32'(ch_done), 32'b0100);
      if (e == 9) check("t2_busy9", 32'(busy), 32'd1);
      if (e == 10) begin
        check("t2_done10", 32'(ch_done), 32'b1000);
        check("t2_busy10", 32'(busy), 32'd0);
        check("t2_killed", 32'(ch_killed), 32'd0);
      end
    end
    check("t2_join_count", 32'(jc), 32'd1);

    // join all, ch3 disabled, zero delay on a disabled branch
    launch(2'd0, 4'b0111, pk(3, 3, 7, 0));
    check("t3_running0", 32'(running), 32'b0111);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3) begin
        check("t3_done3", 32'(ch_done), 32'b0011);
        check("t3_join3", 32'(join_done), 32'd0);
      end
      if (e == 7) begin
        check("t3_done7", 32'(ch_done), 32'b0100);
        check("t3_join7", 32'(join_done), 32'd1);
        check("t3_busy7", 32'(busy), 32'd0);
      end
    end

    // join any with a tie at edge 4
    launch(2'd1, 4'b1111, pk(5, 4, 4, 9));
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 4) begin
        check("t4_done4", 32'(ch_done), 32'b0110);
        check("t4_join4", 32'(join_done), 32'd1);
        check("t4_first", 32'(first_id), 32'd1);
        check("t4_busy4", 32'(busy), 32'd1);
      end
      if (e == 5) check("t4_done5", 32'(ch_done), 32'b0001);
      if (e == 9) begin
        check("t4_done9", 32'(ch_done), 32'b1000);
        check("t4_busy9", 32'(busy), 32'd0);
      end
    end

    // disable at edge 6 beats a simultaneous start; start at edge 7 accepted
    launch(2'd0, 4'b1111, pk(10, 10, 10, 10));
    repeat (5) tick();
    disable_i = 1'b1; start = 1'b1; mode = 2'd0; en_mask = 4'b0001; delay = pk(2, 2, 2, 2);
    tick();
    disable_i = 1'b0;
    check("t5_killed", 32'(ch_killed), 32'b1111);
    check("t5_aborted", 32'(aborted), 32'd1);
    check("t5_join", 32'(join_done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("t5_restart_killed", 32'(ch_killed), 32'd0);
    check("t5_restart_aborted", 32'(aborted), 32'd0);
    check("t5_restart_running", 32'(running), 32'b0001);
    tick(); tick();
    check("t5_done", 32'(ch_done), 32'b0001);
    check("t5_join2", 32'(join_done), 32'd1);
    tick();

    // reset mid-run at edge 3, relaunch at edge 4
    launch(2'd1, 4'b1111, pk(8, 8, 8, 8));
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_running", 32'(running), 32'd0);
    check("t6_done", 32'(ch_done), 32'd0);
    launch(2'd1, 4'b1111, pk(8, 8, 8, 8));
    check("t6_relaunch", 32'(running), 32'b1111);
    for (int e = 5; e <= 12; e++) begin
      tick();
      if (e == 8) check("t6_no_done8", 32'(ch_done), 32'd0);
      if (e == 12) begin
        check("t6_done12", 32'(ch_done), 32'b1111);
        check("t6_join12", 32'(join_done), 32'd1);
        check("t6_busy12", 32'(busy), 32'd0);
      end
    end

    // empty launch
    launch(2'd0, 4'b0000, pk(3, 3, 3, 3));
    check("t7_busy0", 32'(busy), 32'd1);
    tick();
    check("t7_join", 32'(join_done), 32'd1);
    check("t7_busy1", 32'(busy), 32'd0);
    tick();
    check("t7_join_once", 32'(join_done), 32'd0);

    // disable coincides with ch0 completion
    launch(2'd0, 4'b1111, pk(3, 5, 5, 5));
    tick(); tick();
    disable_i = 1'b1;
    tick();
    disable_i = 1'b0;
    check("t8_done", 32'(ch_done), 32'b0001);
    check("t8_killed", 32'(ch_killed), 32'b1110);
    check("t8_aborted", 32'(aborted), 32'd1);
    check("t8_join", 32'(join_done), 32'd1);
    tick();

    // any-with-kill, simultaneous finishers are not killed
    launch(2'd3, 4'b1111, pk(4, 2, 2, 6));
    tick(); tick();
    check("t9_done", 32'(ch_done), 32'b0110);
    check("t9_killed", 32'(ch_killed), 32'b1001);
    check("t9_first", 32'(first_id), 32'd1);
    check("t9_aborted", 32'(aborted), 32'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
